// File: rtl/fp32_div_pkg.sv
// Shared constants, state encoding and result payload for the sequential FP32 divider.
// FP32_DIV_ROUND_EN (when defined) adds one guard iteration for round-to-nearest-even.
package fp32_div_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned MANT_W  = FRAC_W + 1;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 254;
    localparam int unsigned E_W     = 10;
    localparam int unsigned WORD_W  = 32;

`ifdef FP32_DIV_ROUND_EN
    localparam int unsigned ITERS = 26;
`else
    localparam int unsigned ITERS = 25;
`endif

    // Quotient holds one bit per iteration; remainder keeps headroom for the shift.
    localparam int unsigned Q_W   = ITERS;
    localparam int unsigned REM_W = MANT_W + 2;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] c;
        logic              overflow;
        logic              div_by_zero;
    } div_result_t;

endpackage

// File: rtl/fp32_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// Ports: rem/divisor in; rem_next (already shifted) and q_bit out. Purely combinational.
module fp32_div_step
    import fp32_div_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [REM_W-1:0] divisor,
    output logic [REM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [REM_W-1:0] diff;

    always_comb begin
        q_bit    = (rem >= divisor);
        diff     = q_bit ? (rem - divisor) : rem;
        rem_next = diff << 1;
    end

endmodule

// File: rtl/seq_fp32_divider.sv
// Sequential FP32 divider: restoring mantissa divide, one quotient bit per cycle.
// Ports: clk, rst (async active-low), start, a, b in; busy, done, c, overflow,
// div_by_zero out (all registered). Denormals flush to zero, exponent 255 is an
// ordinary number. Define FP32_DIV_ROUND_EN for round-to-nearest-even (one extra
// iteration, latency 28); otherwise the quotient is truncated (latency 27).
module seq_fp32_divider
    import fp32_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] c,
    output logic        overflow,
    output logic        div_by_zero
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  iter_cnt;
    logic              sign_r;
    logic [EXP_W-1:0]  ea_r, eb_r;
    logic [REM_W-1:0]  rem_r, div_r, rem_nxt;
    logic [Q_W-1:0]    quo_r;
    logic              q_bit;
    div_result_t       res_r, norm_c;

    logic signed [E_W-1:0] e_base, e_c;
    logic [FRAC_W-1:0]     frac_c;
    logic                  norm_hi;
`ifdef FP32_DIV_ROUND_EN
    logic                  guard_c, sticky_c, round_up_c;
    logic [FRAC_W:0]       frac_rnd_c;
`endif

    fp32_div_step u_step (
        .rem      (rem_r),
        .divisor  (div_r),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (iter_cnt == CNT_W'(ITERS - 1)) state_nxt = S_NORM;
            S_NORM:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Normalisation, optional rounding, exponent range check and special cases
    always_comb begin
        norm_c  = '0;
        norm_hi = quo_r[Q_W-1];
        e_base  = $signed(E_W'(ea_r)) - $signed(E_W'(eb_r)) + $signed(E_W'(BIAS));
        e_c     = norm_hi ? e_base : (e_base - $signed(E_W'(1)));
        frac_c  = norm_hi ? quo_r[Q_W-2 -: FRAC_W] : quo_r[Q_W-3 -: FRAC_W];
`ifdef FP32_DIV_ROUND_EN
        guard_c    = norm_hi ? quo_r[1] : quo_r[0];
        sticky_c   = (rem_r != '0) || (norm_hi && quo_r[0]);
        round_up_c = guard_c && (sticky_c || frac_c[0]);
        frac_rnd_c = {1'b0, frac_c} + (FRAC_W + 1)'(round_up_c);
        frac_c     = frac_rnd_c[FRAC_W-1:0];
        // Mantissa rounded up to 2.0: fraction wraps to zero, exponent bumps
        if (frac_rnd_c[FRAC_W]) e_c = e_c + $signed(E_W'(1));
`endif
        if (eb_r == '0) begin
            norm_c.div_by_zero = 1'b1;
        end else if (ea_r == '0) begin
            norm_c.c = '0;
        end else if ((e_c > $signed(E_W'(EXP_MAX))) || (e_c < $signed(E_W'(1)))) begin
            norm_c.overflow = 1'b1;
        end else begin
            norm_c.c = {sign_r, e_c[EXP_W-1:0], frac_c};
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt    <= '0;
            sign_r      <= 1'b0;
            ea_r        <= '0;
            eb_r        <= '0;
            rem_r       <= '0;
            div_r       <= '0;
            quo_r       <= '0;
            res_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            c           <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        sign_r   <= a[31] ^ b[31];
                        ea_r     <= a[30:23];
                        eb_r     <= b[30:23];
                        rem_r    <= REM_W'({1'b1, a[FRAC_W-1:0]});
                        div_r    <= REM_W'({1'b1, b[FRAC_W-1:0]});
                        quo_r    <= '0;
                        iter_cnt <= '0;
                    end
                end
                S_CALC: begin
                    rem_r    <= rem_nxt;
                    quo_r    <= {quo_r[Q_W-2:0], q_bit};
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    res_r <= norm_c;
                end
                S_DONE: begin
                    done        <= 1'b1;
                    c           <= res_r.c;
                    overflow    <= res_r.overflow;
                    div_by_zero <= res_r.div_by_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fp32_divider.sv
// Bench for seq_fp32_divider: directed vector table, multi-cycle corner sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_seq_fp32_divider;

`ifdef FP32_DIV_ROUND_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] c;
    logic        overflow, div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_fp32_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .c           (c),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] ec;
        logic        eo;
        logic        ed;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Quotient from exact integer arithmetic on the significands.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rc, output logic ro, output logic rd);
        int ex, ey, e, s;
        longint unsigned mx, my, num, mant, rem;
        rc = 32'h0; ro = 1'b0; rd = 1'b0;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ey == 0) begin rd = 1'b1; return; end
        if (ex == 0) return;
        mx = 64'(x[22:0]) | (64'd1 << 23);
        my = 64'(y[22:0]) | (64'd1 << 23);
        if (mx >= my) begin s = 23; e = ex - ey + 127; end
        else          begin s = 24; e = ex - ey + 126; end
        num  = mx << s;
        mant = num / my;
        rem  = num % my;
`ifdef FP32_DIV_ROUND_EN
        if ((2 * rem > my) || ((2 * rem == my) && ((mant & 64'd1) != 0))) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
`endif
        if (e > 254 || e < 1) begin ro = 1'b1; return; end
        rc = {x[31] ^ y[31], 8'(e), 23'(mant)};
    endfunction

    // Waits up to 60 edges for done; lat = edges since acceptance, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ec,
                         input logic eo, input logic ed, input string name);
        int lat;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        chk({name, " busy_acc"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({name, " latency"}, 32'(lat), 32'(LAT));
        if (lat < 0) return;
        chk({name, " c"}, c, ec);
        chk({name, " ovf"}, 32'(overflow), 32'(eo));
        chk({name, " dz"}, 32'(div_by_zero), 32'(ed));
        chk({name, " busy_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, 32'(done), 32'd0);
        chk({name, " busy_end"}, 32'(busy), 32'd0);
        chk({name, " c_held"}, c, ec);
    endtask

    vec_t vecs[11];

    initial begin
        int lat, extra;
        logic [31:0] ra, rb, rc;
        logic ro, rd;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
`ifdef FP32_DIV_ROUND_EN
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0};
`else
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0};
`endif
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h7F000000, 32'h00800000, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
        vecs[6]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
        vecs[8]  = '{32'h7F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{32'h7F800000, 32'h40000000, 32'h7F000000, 1'b0, 1'b0};
        vecs[10] = '{32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};

        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst c", c, 32'h0);
        chk("rst flags", 32'({overflow, div_by_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op(vecs[i].va, vecs[i].vb, vecs[i].ec, vecs[i].eo, vecs[i].ed,
                  $sformatf("vec%0d", i));

        // start held high through the operation while operands change
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        chk("hold latency", 32'(lat), 32'(LAT));
        chk("hold c", c, 32'h40400000);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("hold extra_done", 32'(extra), 32'd0);
        chk("hold busy_idle", 32'(busy), 32'd0);

        // start pulse while busy is ignored
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin start = 1'b1; a = 32'h40C00000; b = 32'h40000000; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        chk("busy_start latency", 32'(lat), 32'(LAT));
        chk("busy_start c", c, 32'h3F000000);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("busy_start extra_done", 32'(extra), 32'd0);

        // reset during CALC, then immediate restart
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst c", c, 32'h0);
        chk("midrst flags", 32'({overflow, div_by_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b1; a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("postrst busy_acc", 32'(busy), 32'd1);
        wait_done(lat);
        chk("postrst latency", 32'(lat), 32'(LAT));
        chk("postrst c", c, 32'h40400000);

        // randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ex [2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 9))
                    0:       ex[j] = 8'd0;
                    1:       ex[j] = 8'd255;
                    2, 3:    ex[j] = 8'($urandom_range(1, 254));
                    default: ex[j] = 8'($urandom_range(100, 154));
                endcase
            end
            ra = $urandom; rb = $urandom;
            ra[30:23] = ex[0];
            rb[30:23] = ex[1];
            ref_div(ra, rb, rc, ro, rd);
            do_op(ra, rb, rc, ro, rd, $sformatf("rnd%0d a=%h b=%h", i, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
